// File: rtl/mem_bus_master.sv
// Single-port memory bus master: takes one request at a time, sequences
// addr / wm / wb and the shared data bus, and returns a registered response.
module mem_bus_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              wm,
  output logic              wb,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wm_q, wm_d;
  logic              wb_q, wb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = SETUP;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      SETUP: begin
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
          cnt_d   = WAIT_LOAD;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      READ: begin
        // The edge that ends the last wait cycle samples the bus.
        if (cnt_q <= WAIT_LAST) begin
          cnt_d   = '0;
          rdata_d = data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_LAST;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    wm_d        = (state_d == WRITE);
    wb_d        = (state_d == READ);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
    // The first IDLE cycle after a response never accepts.
    ready_d     = (state_d == IDLE) && (state_q != RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      wm_q        <= 1'b0;
      wb_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      wm_q        <= wm_d;
      wb_q        <= wb_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign data      = wm_q ? wdata_q : {DATA_W{1'bz}};
  assign addr      = addr_q;
  assign wm        = wm_q;
  assign wb        = wb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (RD_WAIT=1 and RD_WAIT=3) share the
// request inputs, each with its own behavioural memory on its data bus.
module tb_mem_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       req_valid, req_we, rsp_ready;
  logic [7:0] req_addr, req_wdata;

  logic       a_req_ready, a_rsp_valid, a_wm, a_wb, a_busy;
  logic [7:0] a_rsp_rdata, a_addr;
  wire  [7:0] a_data;
  logic [7:0] a_mem [256];

  logic       b_req_ready, b_rsp_valid, b_wm, b_wb, b_busy;
  logic [7:0] b_rsp_rdata, b_addr;
  wire  [7:0] b_data;
  logic [7:0] b_mem [256];

  wire a_req_valid = req_valid & ~sel;
  wire b_req_valid = req_valid & sel;

  mem_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
    .addr(a_addr), .wm(a_wm), .wb(a_wb), .data(a_data), .busy(a_busy)
  );

  mem_bus_master #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
    .addr(b_addr), .wm(b_wm), .wb(b_wb), .data(b_data), .busy(b_busy)
  );

  // Memories drive the bus while wb is high and store on edges with wm high.
  assign a_data = a_wb ? a_mem[a_addr] : 8'hzz;
  assign b_data = b_wb ? b_mem[b_addr] : 8'hzz;
  always @(posedge clk) if (a_wm) a_mem[a_addr] <= a_data;
  always @(posedge clk) if (b_wm) b_mem[b_addr] <= b_data;

  wire       c_req_ready = sel ? b_req_ready : a_req_ready;
  wire       c_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  wire       c_wm        = sel ? b_wm        : a_wm;
  wire       c_wb        = sel ? b_wb        : a_wb;
  wire       c_busy      = sel ? b_busy      : a_busy;
  wire [7:0] c_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  wire [7:0] c_addr      = sel ? b_addr      : a_addr;
  wire [7:0] c_data      = sel ? b_data      : a_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         lat;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One access on the selected instance, checked cycle by cycle until the
  // response, then held for 'hold' cycles of backpressure before release.
  task automatic access(input logic we, input logic [7:0] ad, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input int exp_lat, input int rdw,
                        input int hold, input string nm);
    int t, cyc, nwm, nwb, wm_at, bad;
    t = 0;
    while (!c_req_ready && t < 20) begin
      step();
      t++;
    end
    check({nm, " ready"}, {31'd0, c_req_ready}, 32'd1);
    req_we    = we;
    req_addr  = ad;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 1; nwm = 0; nwb = 0; wm_at = 0; bad = 0;
    while (!c_rsp_valid && cyc < 20) begin
      if (c_wm) begin
        nwm++;
        wm_at = cyc;
        if (c_data !== wd) bad++;
      end
      if (c_wb) nwb++;
      if (c_wm && c_wb) bad++;
      if (c_addr !== ad) bad++;
      step();
      cyc++;
    end
    check({nm, " latency"}, cyc, exp_lat);
    check({nm, " wm cycles"}, nwm, we ? 1 : 0);
    check({nm, " wm cycle index"}, wm_at, we ? 2 : 0);
    check({nm, " wb cycles"}, nwb, we ? 0 : rdw);
    check({nm, " bus violations"}, bad, 0);
    check({nm, " rsp_rdata"}, {24'd0, c_rsp_rdata}, {24'd0, exp_rd});
    req_valid = (hold != 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({nm, " held rsp"},
            {19'd0, c_rsp_valid, c_req_ready, c_wm, c_wb, c_busy, c_addr, c_rsp_rdata},
            {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ad, exp_rd});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    check({nm, " rsp retired"}, {30'd0, c_rsp_valid, c_busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] model [16];
    logic [7:0] b_last;
    logic       bwe [4];
    logic [7:0] badr [4];
    logic [7:0] bwd [4];
    logic [7:0] bexp [4];
    int         t, cyc, acc_cnt, last_acc, rsp_idx;
    logic       prev_busy;
    logic       we;
    logic [7:0] ad, wd;

    vt[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 3};
    vt[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 3};
    vt[2] = '{1'b1, 8'hFF, 8'hC3, 8'h5A, 3};
    vt[3] = '{1'b1, 8'h00, 8'h77, 8'h5A, 3};
    vt[4] = '{1'b0, 8'h00, 8'h00, 8'h77, 3};
    vt[5] = '{1'b1, 8'h01, 8'h00, 8'h77, 3};
    vt[6] = '{1'b0, 8'h01, 8'h00, 8'h00, 3};
    vt[7] = '{1'b1, 8'h80, 8'hA5, 8'h00, 3};
    vt[8] = '{1'b0, 8'h80, 8'h00, 8'hA5, 3};
    vt[9] = '{1'b0, 8'h10, 8'h00, 8'h5A, 3};

    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_addr = 8'h00; req_wdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset busy", {31'd0, a_busy}, 32'd0);
    check("reset strobes", {30'd0, a_wm, a_wb}, 32'd0);
    check("reset rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("reset rsp_rdata", {24'd0, a_rsp_rdata}, 32'd0);
    check("reset addr", {24'd0, a_addr}, 32'd0);
    rst_n = 1'b1;
    step();
    check("ready after reset", {31'd0, a_req_ready}, 32'd1);

    for (int i = 0; i < 10; i++)
      access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].lat, 1, 0,
             $sformatf("vec%0d", i));

    access(1'b0, 8'hFF, 8'h00, 8'hC3, 3, 1, 5, "backpressure");

    // Reset during the READ cycle aborts the access.
    t = 0;
    while (!a_req_ready && t < 20) begin
      step();
      t++;
    end
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("midrst wb in READ", {31'd0, a_wb}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst strobes drop", {30'd0, a_wm, a_wb}, 32'd0);
    check("midrst no response", {30'd0, a_rsp_valid, a_busy}, 32'd0);
    check("midrst addr", {24'd0, a_addr}, 32'd0);
    step();
    check("midrst held", {29'd0, a_rsp_valid, a_wm, a_wb}, 32'd0);
    rst_n = 1'b1;
    step();
    check("midrst ready", {31'd0, a_req_ready}, 32'd1);
    check("midrst rsp_rdata", {24'd0, a_rsp_rdata}, 32'd0);

    // Back-to-back alternating write/read with req_valid held high.
    bwe  = '{1'b1, 1'b0, 1'b1, 1'b0};
    badr = '{8'h20, 8'h20, 8'h21, 8'h21};
    bwd  = '{8'h11, 8'h00, 8'h22, 8'h00};
    bexp = '{8'h00, 8'h11, 8'h00, 8'h22};
    req_we = bwe[0]; req_addr = badr[0]; req_wdata = bwd[0];
    req_valid = 1'b1; rsp_ready = 1'b1;
    prev_busy = a_busy; acc_cnt = 0; last_acc = 0; rsp_idx = 0; cyc = 0;
    while (cyc < 80 && rsp_idx < 4) begin
      step();
      cyc++;
      if (a_busy && !prev_busy) begin
        if (acc_cnt > 0) check("b2b period", cyc - last_acc, 5);
        last_acc = cyc;
        acc_cnt++;
        if (acc_cnt < 4) begin
          req_we = bwe[acc_cnt]; req_addr = badr[acc_cnt]; req_wdata = bwd[acc_cnt];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (a_rsp_valid) begin
        if (!bwe[rsp_idx]) check("b2b read data", {24'd0, a_rsp_rdata}, {24'd0, bexp[rsp_idx]});
        rsp_idx++;
      end
      prev_busy = a_busy;
    end
    req_valid = 1'b0;
    check("b2b responses", rsp_idx, 4);
    check("b2b acceptances", acc_cnt, 4);
    step();

    // Mixed traffic on the RD_WAIT=3 instance against a reference memory.
    sel = 1'b1;
    b_last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      model[i] = 8'(i * 13 + 7);
      access(1'b1, 8'(i), model[i], b_last, 3, 3, 0, $sformatf("init%0d", i));
    end
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      ad = 8'($urandom_range(0, 15));
      wd = 8'($urandom);
      if (we) begin
        access(1'b1, ad, wd, b_last, 3, 3, 0, $sformatf("rnd%0d wr", i));
        model[ad[3:0]] = wd;
      end else begin
        b_last = model[ad[3:0]];
        access(1'b0, ad, 8'h00, b_last, 5, 3, 0, $sformatf("rnd%0d rd", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
